// File: rtl/jtkcpu_muldiv.sv
// Iterative radix-2 multiply/divide unit for the JTKCPU execution stage.
// One shift-add (MUL) or restoring shift-subtract (DIV) step per cen edge.
module jtkcpu_muldiv #(
    parameter int W = 16
) (
    input  logic         rst,
    input  logic         clk,
    input  logic         cen,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] opnd0,
    input  logic [W-1:0] opnd1,
    input  logic [7:0]   cc_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] rslt_hi,
    output logic [W-1:0] rslt_lo,
    output logic [7:0]   cc_out
);
    localparam int CW = $clog2(W) + 1;
    localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DZERO} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           is_div, neg_q, neg_r, ovf;
    logic [3:0]     cc_hi;
    logic [W-1:0]   opa, opb, acc_hi, acc_lo;
    logic [W-1:0]   mag0, mag1;
    logic           last_step, div0;
    logic [2*W-1:0] prod_nxt, prod_fix;
    logic [W:0]     rem_sh, rem_try;
    logic [W-1:0]   rem_nxt, quo_nxt, q_fix, r_fix;
    logic [W-1:0]   fin_hi, fin_lo;
    logic [3:0]     fin_cc;
    logic           cc_unused;

    function automatic logic [W-1:0] abs_w(input logic signed [W-1:0] x, input logic sgn);
        return (sgn && x < 0) ? -x : x;
    endfunction

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] x, input logic c);
        return c ? -x : x;
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x, input logic c);
        return c ? -x : x;
    endfunction

    // Low flag bits of cc_in are always recomputed, so only 7:4 are kept
    assign cc_unused = ^cc_in[3:0];

    assign busy      = (state != IDLE);
    assign last_step = (cnt == CW'(W-1));
    assign div0      = op[1] && (opnd1 == '0);
    assign mag0      = abs_w(opnd0, op[0]);
    assign mag1      = abs_w(opnd1, op[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state <= IDLE;
        else if (cen) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = div0 ? DZERO : RUN;
            RUN:     if (last_step) state_nxt = IDLE;
            DZERO:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One radix-2 step and the sign-fixed final result it would produce
    always_comb begin
        prod_nxt = {acc_hi[W-2:0], acc_lo, 1'b0} + (opb[W-1] ? {{W{1'b0}}, opa} : '0);
        rem_sh   = {acc_hi, acc_lo[W-1]};
        rem_try  = rem_sh - {1'b0, opb};
        rem_nxt  = rem_try[W] ? rem_sh[W-1:0] : rem_try[W-1:0];
        quo_nxt  = {acc_lo[W-2:0], ~rem_try[W]};
        prod_fix = neg_2w(prod_nxt, neg_q);
        q_fix    = neg_w(quo_nxt, neg_q);
        r_fix    = neg_w(rem_nxt, neg_r);
        if (is_div) begin
            fin_hi = r_fix;
            fin_lo = q_fix;
            fin_cc = {q_fix[W-1], q_fix == '0, ovf, r_fix != '0};
        end else begin
            fin_hi = prod_fix[2*W-1:W];
            fin_lo = prod_fix[W-1:0];
            fin_cc = {prod_fix[2*W-1], prod_fix == '0, 1'b0, prod_fix[W-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done    <= 1'b0;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            ovf     <= 1'b0;
            cc_hi   <= '0;
            opa     <= '0;
            opb     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            rslt_hi <= '0;
            rslt_lo <= '0;
            cc_out  <= '0;
        end else if (cen) begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cnt    <= '0;
                    is_div <= op[1];
                    neg_q  <= op[0] & (opnd0[W-1] ^ opnd1[W-1]);
                    neg_r  <= op[0] & opnd0[W-1];
                    ovf    <= (op == 2'b11) && (opnd0 == MIN_INT) && (&opnd1);
                    cc_hi  <= cc_in[7:4];
                    opa    <= mag0;
                    opb    <= mag1;
                    acc_hi <= '0;
                    // divide by zero reports the raw dividend as remainder
                    acc_lo <= op[1] ? (div0 ? opnd0 : mag0) : '0;
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        acc_hi <= rem_nxt;
                        acc_lo <= quo_nxt;
                    end else begin
                        {acc_hi, acc_lo} <= prod_nxt;
                        opb <= {opb[W-2:0], 1'b0};
                    end
                    if (last_step) begin
                        rslt_hi <= fin_hi;
                        rslt_lo <= fin_lo;
                        cc_out  <= {cc_hi, fin_cc};
                        done    <= 1'b1;
                        cnt     <= '0;
                    end
                end
                DZERO: begin
                    rslt_hi <= acc_lo;
                    rslt_lo <= '1;
                    cc_out  <= {cc_hi, 1'b1, 1'b0, 1'b1, acc_lo != '0};
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jtkcpu_muldiv.sv
// Directed bench for jtkcpu_muldiv (W=16): hand-computed vectors with immediate assertions.
module tb_jtkcpu_muldiv;
    localparam int W = 16;

    logic         clk = 1'b0, rst = 1'b1, cen = 1'b1, start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] opnd0 = '0, opnd1 = '0;
    logic [7:0]   cc_in = '0;
    logic         busy, done;
    logic [W-1:0] rslt_hi, rslt_lo;
    logic [7:0]   cc_out;

    int vecs = 0;
    int errs = 0;
    int n, n2, seen;

    jtkcpu_muldiv #(.W(W)) dut (
        .rst(rst), .clk(clk), .cen(cen), .start(start), .op(op),
        .opnd0(opnd0), .opnd1(opnd1), .cc_in(cc_in),
        .busy(busy), .done(done), .rslt_hi(rslt_hi), .rslt_lo(rslt_lo), .cc_out(cc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [7:0] c);
        op = o; opnd0 = a; opnd1 = b; cc_in = c; start = 1'b1;
        step();
        start = 1'b0;
        opnd0 = ~a; opnd1 = ~b; cc_in = ~c;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < 100) begin
            step();
            cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [7:0] c, input int exp_n,
                          input logic [W-1:0] e_hi, input logic [W-1:0] e_lo, input logic [7:0] e_cc);
        int k;
        launch(o, a, b, c);
        chk({tag, "/busy_rise"}, 32'(busy), 32'd1);
        chk({tag, "/done_clr"}, 32'(done), 32'd0);
        wait_done(k);
        chk({tag, "/latency"}, 32'(k), 32'(exp_n));
        chk({tag, "/hi"}, 32'(rslt_hi), 32'(e_hi));
        chk({tag, "/lo"}, 32'(rslt_lo), 32'(e_lo));
        chk({tag, "/cc"}, 32'(cc_out), 32'(e_cc));
        chk({tag, "/busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        step();
        step();
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/hi", 32'(rslt_hi), 32'd0);
        chk("rst/lo", 32'(rslt_lo), 32'd0);
        chk("rst/cc", 32'(cc_out), 32'd0);
        rst = 1'b0;
        step();

        run_op("mulu_ffff", 2'b00, 16'hFFFF, 16'hFFFF, 8'hA0, 16, 16'hFFFE, 16'h0001, 8'hA8);
        run_op("muls_neg",  2'b01, 16'hFFFF, 16'h0002, 8'h00, 16, 16'hFFFF, 16'hFFFE, 8'h09);
        run_op("mulu_zero", 2'b00, 16'h0000, 16'h1234, 8'h00, 16, 16'h0000, 16'h0000, 8'h04);
        run_op("divu",      2'b10, 16'h03E8, 16'h0007, 8'h00, 16, 16'h0006, 16'h008E, 8'h01);
        run_op("divs_neg",  2'b11, 16'hFFF9, 16'h0002, 8'h00, 16, 16'hFFFF, 16'hFFFD, 8'h09);
        run_op("divs_ovf",  2'b11, 16'h8000, 16'hFFFF, 8'h00, 16, 16'h0000, 16'h8000, 8'h0A);
        run_op("div_zero",  2'b10, 16'h1234, 16'h0000, 8'h00, 1,  16'h1234, 16'hFFFF, 8'h0B);

        // Second start at edge 5 must not disturb the operation in flight
        launch(2'b00, 16'h1234, 16'h0010, 8'h50);
        repeat (4) step();
        op = 2'b01; opnd0 = 16'hFFFF; opnd1 = 16'hFFFF; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(n);
        chk("restart/latency", 32'(n + 5), 32'd16);
        chk("restart/hi", 32'(rslt_hi), 32'h0001);
        chk("restart/lo", 32'(rslt_lo), 32'h2340);
        chk("restart/cc", 32'(cc_out), 32'h50);

        // cen held low for 3 clocks mid-operation
        launch(2'b01, 16'h0003, 16'hFFFE, 8'h00);
        repeat (4) step();
        cen = 1'b0;
        repeat (3) step();
        cen = 1'b1;
        wait_done(n);
        chk("cen/clocks", 32'(n + 7), 32'd19);
        chk("cen/hi", 32'(rslt_hi), 32'hFFFF);
        chk("cen/lo", 32'(rslt_lo), 32'hFFFA);
        chk("cen/cc", 32'(cc_out), 32'h09);
        cen = 1'b0;
        repeat (2) step();
        chk("cen/done_hold", 32'(done), 32'd1);
        cen = 1'b1;
        step();
        chk("cen/done_fall", 32'(done), 32'd0);
        chk("cen/hold_lo", 32'(rslt_lo), 32'hFFFA);

        // Asynchronous reset in the middle of an operation
        launch(2'b00, 16'hFFFF, 16'hFFFF, 8'hF0);
        repeat (7) step();
        #2 rst = 1'b1;
        #1;
        chk("abort/busy", 32'(busy), 32'd0);
        chk("abort/done", 32'(done), 32'd0);
        chk("abort/hi", 32'(rslt_hi), 32'd0);
        chk("abort/lo", 32'(rslt_lo), 32'd0);
        chk("abort/cc", 32'(cc_out), 32'd0);
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done === 1'b1) seen++;
        end
        chk("abort/no_done", 32'(seen), 32'd0);
        chk("abort/idle", 32'(busy), 32'd0);

        // Fresh operation after the abort still works
        run_op("post_rst", 2'b10, 16'h0064, 16'h000A, 8'h30, 16, 16'h0000, 16'h000A, 8'h30);
        n2 = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
